// File: rtl/lcd_pkg.sv
// Shared constants and state encoding for the character LCD frame sequencer.
// Holds the HD44780 command bytes and the power-up command order.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;
  localparam logic [7:0] SPACE        = 8'h20;

  localparam int FRAME_CHARS = 32;

  typedef enum logic [2:0] {
    INIT_CMD,
    INIT_WAIT,
    IDLE,
    ADDR,
    CHAR,
    GAP_WAIT,
    DONE
  } state_t;

  // Power-up order; the clear command comes last and gets the long settle time.
  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    logic [7:0] cmd;
    case (step)
      2'd0:    cmd = CMD_FUNC_SET;
      2'd1:    cmd = CMD_DISP_ON;
      2'd2:    cmd = CMD_ENTRY;
      default: cmd = CMD_CLEAR;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_pace_timer.sv
// Down-counter that spaces LCD writes: loaded on start, expired while the count is zero.
// The count equals the load value in the cycle right after start.
module lcd_pace_timer #(
  parameter int W = 22
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] load,
  output logic         expired
);

  logic [W-1:0] count;

  // NOTE: clocked state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (start)
      count <= load;
    else if (count != '0)
      count <= count - W'(1);
  end

  assign expired = (count == '0);

endmodule

// File: rtl/lcd_frame_sequencer.sv
// Drives the LCD write port: power-up commands, then paced 34-write frames from a
// 32-character buffer, re-sent whenever the buffer changes or a refresh is requested.
module lcd_frame_sequencer
  import lcd_pkg::*;
#(
  parameter int GAP_CYCLES = 1600000,
  parameter int CLEAR_GAP  = 3200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       buf_we,
  input  logic [4:0] buf_addr,
  input  logic [7:0] buf_data,
  input  logic       refresh_req,
  output logic       lcd_wr_en,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  output logic       busy,
  output logic       init_done,
  output logic       frame_done
);

  localparam int CNT_W = $clog2(CLEAR_GAP + 1);
  // The wait state plus the following issue state add two cycles to the timer load.
  // After the clear, the IDLE and ADDR cycles sit between the wait and the 0x80 pulse.
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'((CLEAR_GAP >= 2) ? CLEAR_GAP - 2 : 0);

  state_t           state, next_state;
  logic [4:0]       idx;
  logic             after_addr;
  logic             last_char;
  logic             dirty;
  logic             pending;
  logic [7:0]       frame_buf [FRAME_CHARS];

  logic             issue;
  logic             issue_rs;
  logic [7:0]       issue_data;
  logic             timer_start;
  logic [CNT_W-1:0] timer_load;
  logic             timer_expired;
  logic             frame_start;
  logic             init_finish;

  lcd_pace_timer #(.W(CNT_W)) u_pace_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (timer_start),
    .load    (timer_load),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= INIT_CMD;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      INIT_CMD:  next_state = INIT_WAIT;
      INIT_WAIT: if (timer_expired) next_state = (idx == 5'd4) ? IDLE : INIT_CMD;
      IDLE:      if (dirty || pending) next_state = ADDR;
      ADDR:      next_state = GAP_WAIT;
      CHAR:      next_state = GAP_WAIT;
      GAP_WAIT: begin
        if (timer_expired) begin
          if (last_char)
            next_state = DONE;
          else if (idx == 5'd16 && !after_addr)
            next_state = ADDR;
          else
            next_state = CHAR;
        end
      end
      DONE:      next_state = IDLE;
      default:   next_state = INIT_CMD;
    endcase
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    issue       = 1'b0;
    issue_rs    = 1'b0;
    issue_data  = 8'h00;
    timer_start = 1'b0;
    timer_load  = GAP_LOAD;
    unique case (state)
      INIT_CMD: begin
        issue       = 1'b1;
        issue_data  = init_cmd(idx[1:0]);
        timer_start = 1'b1;
        if (idx[1:0] == 2'd3) timer_load = CLEAR_LOAD;
      end
      ADDR: begin
        issue       = 1'b1;
        issue_data  = idx[4] ? CMD_LINE2 : CMD_LINE1;
        timer_start = 1'b1;
      end
      CHAR: begin
        issue       = 1'b1;
        issue_rs    = 1'b1;
        issue_data  = frame_buf[idx];
        timer_start = 1'b1;
      end
      default: ;
    endcase
  end

  assign frame_start = (state == IDLE) && (next_state == ADDR);
  assign init_finish = (state == INIT_WAIT) && (next_state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      lcd_wr_en  <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_data   <= 8'h00;
      busy       <= 1'b1;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      lcd_wr_en  <= issue;
      frame_done <= (state == DONE);
      if (issue) begin
        lcd_rs   <= issue_rs;
        lcd_data <= issue_data;
      end
      if (init_finish) begin
        init_done <= 1'b1;
        busy      <= 1'b0;
      end
      if (state == ADDR && !idx[4]) busy <= 1'b1;
      if (state == DONE)            busy <= 1'b0;
    end
  end

  // Index stops at 31; the line switch is the extra ADDR write inserted at index 16.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= '0;
      after_addr <= 1'b0;
      last_char  <= 1'b0;
    end else begin
      unique case (state)
        INIT_CMD: idx <= idx + 5'd1;
        IDLE: begin
          if (frame_start) begin
            idx        <= '0;
            after_addr <= 1'b0;
            last_char  <= 1'b0;
          end
        end
        ADDR: after_addr <= 1'b1;
        CHAR: begin
          after_addr <= 1'b0;
          if (idx == 5'd31)
            last_char <= 1'b1;
          else
            idx <= idx + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // A write or refresh landing on the frame-start cycle wins, costing one extra frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      dirty   <= 1'b1;
      pending <= 1'b0;
    end else begin
      if (frame_start) begin
        dirty   <= 1'b0;
        pending <= 1'b0;
      end
      if (buf_we)      dirty   <= 1'b1;
      if (refresh_req) pending <= 1'b1;
    end
  end

  // NOTE: the buffer is reset explicitly because the panel must show blanks after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FRAME_CHARS; i++) frame_buf[i] <= SPACE;
    end else if (buf_we) begin
      frame_buf[buf_addr] <= buf_data;
    end
  end

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Directed bench for lcd_frame_sequencer with GAP_CYCLES=3, CLEAR_GAP=7.
// Pulses are logged on the falling edge and compared against hand-built frames.
module tb_lcd_frame_sequencer;

  typedef struct {
    int         cyc;
    logic       rs;
    logic [7:0] data;
  } init_vec_t;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_vec_t;

  typedef struct {
    int         cyc;
    logic       rs;
    logic [7:0] data;
    logic       init_done;
    logic       busy;
  } pulse_t;

  typedef logic [32*8-1:0] frame_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       buf_we = 1'b0;
  logic [4:0] buf_addr = '0;
  logic [7:0] buf_data = '0;
  logic       refresh_req = 1'b0;
  logic       lcd_wr_en;
  logic       lcd_rs;
  logic [7:0] lcd_data;
  logic       busy;
  logic       init_done;
  logic       frame_done;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         rst_wr_cnt = 0;
  pulse_t     log_q [$];
  int         fd_cyc [$];
  logic       fd_busy [$];
  init_vec_t  init_tab [5];
  wr_vec_t    hello_tab [5];
  frame_t     model;
  frame_t     snap;
  int         base;
  int         fdb;

  lcd_frame_sequencer #(.GAP_CYCLES(3), .CLEAR_GAP(7)) dut (
    .clk         (clk),
    .reset       (reset),
    .buf_we      (buf_we),
    .buf_addr    (buf_addr),
    .buf_data    (buf_data),
    .refresh_req (refresh_req),
    .lcd_wr_en   (lcd_wr_en),
    .lcd_rs      (lcd_rs),
    .lcd_data    (lcd_data),
    .busy        (busy),
    .init_done   (init_done),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  always @(negedge clk) begin
    if (lcd_wr_en === 1'b1) log_q.push_back('{cyc, lcd_rs, lcd_data, init_done, busy});
    if (frame_done === 1'b1) begin
      fd_cyc.push_back(cyc);
      fd_busy.push_back(busy);
    end
    if (reset && lcd_wr_en === 1'b1) rst_wr_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_pulses(input int n, input string tag);
    int k = 0;
    while (log_q.size() < n && k < 2000) begin
      tick();
      k++;
    end
    check({tag, " pulse count"}, 32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic wait_fd(input int n, input string tag);
    int k = 0;
    while (fd_cyc.size() < n && k < 2000) begin
      tick();
      k++;
    end
    check({tag, " frame_done count"}, 32'(fd_cyc.size() >= n), 32'd1);
  endtask

  function automatic logic [8:0] frame_byte(input frame_t fb, input int k);
    if (k == 0)  return {1'b0, 8'h80};
    if (k == 17) return {1'b0, 8'hC0};
    if (k < 17)  return {1'b1, fb[(k-1)*8 +: 8]};
    return {1'b1, fb[(k-2)*8 +: 8]};
  endfunction

  task automatic check_frame(input int b, input frame_t fb, input int fdi, input string tag);
    if (log_q.size() >= b + 34) begin
      for (int k = 0; k < 34; k++) begin
        check($sformatf("%s byte%0d", tag, k), {23'd0, log_q[b+k].rs, log_q[b+k].data},
              {23'd0, frame_byte(fb, k)});
        if (k > 0)
          check($sformatf("%s gap%0d", tag, k), log_q[b+k].cyc - log_q[b+k-1].cyc, 32'd4);
      end
      if (fd_cyc.size() > fdi) begin
        check({tag, " frame_done cycle"}, fd_cyc[fdi], log_q[b+33].cyc + 4);
        check({tag, " busy at frame_done"}, {31'd0, fd_busy[fdi]}, 32'd0);
      end
    end
  endtask

  task automatic check_init(input string tag);
    wait_pulses(5, tag);
    if (log_q.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("%s init cyc%0d", tag, i), log_q[i].cyc, init_tab[i].cyc);
        check($sformatf("%s init byte%0d", tag, i), {23'd0, log_q[i].rs, log_q[i].data},
              {23'd0, init_tab[i].rs, init_tab[i].data});
      end
      check({tag, " init_done before clear done"}, {31'd0, log_q[3].init_done}, 32'd0);
      check({tag, " init_done at 0x80"}, {31'd0, log_q[4].init_done}, 32'd1);
      check({tag, " busy at 0x80"}, {31'd0, log_q[4].busy}, 32'd1);
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    repeat (4) begin
      tick();
      check({tag, " wr_en in reset"}, {31'd0, lcd_wr_en}, 32'd0);
    end
    check({tag, " busy in reset"}, {31'd0, busy}, 32'd1);
    check({tag, " init_done in reset"}, {31'd0, init_done}, 32'd0);
    check({tag, " frame_done in reset"}, {31'd0, frame_done}, 32'd0);
    check({tag, " data in reset"}, {23'd0, lcd_rs, lcd_data}, 32'd0);
    log_q.delete();
    fd_cyc.delete();
    fd_busy.delete();
    model = {32{8'h20}};
    reset = 1'b0;
  endtask

  initial begin
    init_tab[0] = '{1,  1'b0, 8'h38};
    init_tab[1] = '{5,  1'b0, 8'h0C};
    init_tab[2] = '{9,  1'b0, 8'h06};
    init_tab[3] = '{13, 1'b0, 8'h01};
    init_tab[4] = '{21, 1'b0, 8'h80};
    hello_tab[0] = '{5'd0, 8'h48};
    hello_tab[1] = '{5'd1, 8'h45};
    hello_tab[2] = '{5'd2, 8'h4C};
    hello_tab[3] = '{5'd3, 8'h4C};
    hello_tab[4] = '{5'd4, 8'h4F};

    // Power-up, default blank frame, then quiet idle.
    do_reset("A");
    check_init("A");
    wait_pulses(38, "A frame");
    wait_fd(1, "A frame");
    check_frame(4, model, 0, "A blank");
    repeat (20) tick();
    check("A idle no pulses", log_q.size(), 32'd38);
    check("A idle busy", {31'd0, busy}, 32'd0);

    // Write and refresh in the same idle cycle give one frame.
    base = log_q.size();
    fdb = fd_cyc.size();
    buf_we = 1'b1; buf_addr = 5'd20; buf_data = 8'h41; refresh_req = 1'b1;
    model[20*8 +: 8] = 8'h41;
    tick();
    buf_we = 1'b0; refresh_req = 1'b0;
    wait_pulses(base + 34, "B frame");
    wait_fd(fdb + 1, "B frame");
    check_frame(base, model, fdb, "B");
    repeat (20) tick();
    check("B single frame", log_q.size(), base + 34);

    // Writes to already-sent indices, one landing on its issue cycle.
    snap = model;
    base = log_q.size();
    fdb = fd_cyc.size();
    refresh_req = 1'b1;
    tick();
    refresh_req = 1'b0;
    wait_pulses(base + 4, "C char2");
    buf_we = 1'b1; buf_addr = 5'd2; buf_data = 8'h57;
    model[2*8 +: 8] = 8'h57;
    tick();
    buf_we = 1'b0;
    tick();
    buf_we = 1'b1; buf_addr = 5'd3; buf_data = 8'h33;
    model[3*8 +: 8] = 8'h33;
    tick();
    buf_we = 1'b0;
    wait_pulses(base + 68, "C frames");
    wait_fd(fdb + 2, "C frames");
    check_frame(base, snap, fdb, "C old");
    check_frame(base + 34, model, fdb + 1, "C new");
    repeat (20) tick();
    check("C exactly two frames", log_q.size(), base + 68);

    // Three refresh pulses while busy collapse into one extra frame.
    base = log_q.size();
    fdb = fd_cyc.size();
    refresh_req = 1'b1;
    tick();
    refresh_req = 1'b0;
    wait_pulses(base + 3, "D start");
    for (int i = 0; i < 3; i++) begin
      refresh_req = 1'b1;
      tick();
      refresh_req = 1'b0;
      repeat (5) tick();
    end
    wait_pulses(base + 68, "D frames");
    wait_fd(fdb + 2, "D frames");
    check_frame(base, model, fdb, "D first");
    check_frame(base + 34, model, fdb + 1, "D extra");
    repeat (20) tick();
    check("D exactly one extra", log_q.size(), base + 68);
    check("D frame_done count", fd_cyc.size(), fdb + 2);

    // HELLO written during init shows up in the single first frame.
    do_reset("E");
    tick();
    for (int i = 0; i < 5; i++) begin
      buf_we = 1'b1; buf_addr = hello_tab[i].addr; buf_data = hello_tab[i].data;
      model[hello_tab[i].addr*8 +: 8] = hello_tab[i].data;
      tick();
    end
    buf_we = 1'b0;
    check_init("E");
    wait_pulses(38, "E frame");
    wait_fd(1, "E frame");
    check_frame(4, model, 0, "E hello");
    repeat (20) tick();
    check("E single frame", log_q.size(), 32'd38);
    check("E busy after frame", {31'd0, busy}, 32'd0);

    // Reset at pulse 10 of a frame: init restarts and the buffer is blank again.
    refresh_req = 1'b1;
    tick();
    refresh_req = 1'b0;
    wait_pulses(38 + 10, "F pulse10");
    do_reset("F");
    check_init("F");
    wait_pulses(38, "F frame");
    wait_fd(1, "F frame");
    check_frame(4, model, 0, "F blank");
    check("no wr_en during reset", rst_wr_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
